// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment table for the multiplexed 7-segment driver.
// Segments are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    unique case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle: digit data and controls in, anodes/segments out.
// The slave side is the scan driver; the master side is the feeding logic.
interface seg7_scan_mux_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   anode;
  seg_t                    seg;
  logic                    frame_tick;

  modport master (
    output digits, digit_en, lz_blank,
    input  anode, seg, frame_tick
  );

  modport slave (
    input  digits, digit_en, lz_blank,
    output anode, seg, frame_tick
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode scanner with dead-time blanking,
// per-digit enables, leading-zero suppression and per-frame input latching.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 1000,
  parameter int DEAD_CYCLES = 50
) (
  input logic clk,
  input logic reset,
  seg7_scan_mux_if.slave bus
);

  localparam int ND = NUM_DIGITS;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [4*ND-1:0] sh_dig;
  logic [ND-1:0]   sh_en;
  logic            sh_lz;

  logic [ND-1:0]   anode_q;
  seg_t            seg_q;
  logic            tick_q;

  logic [3:0]      nib;
  seg_t            nib_seg;
  logic [ND-1:0]   sup;
  logic            zero_above;
  logic            dead;
  logic            vis;
  logic            wrap;
  logic            last_idx;
  logic            frame_end;

  assign wrap      = (cnt == CW'(SLOT_CYCLES - 1));
  assign last_idx  = (idx == IW'(NUM_DIGITS - 1));
  assign frame_end = wrap && last_idx;

  generate
    if (DEAD_CYCLES == 0) begin : g_nodead
      assign dead = 1'b0;
    end else begin : g_dead
      assign dead = (cnt < CW'(DEAD_CYCLES));
    end
  endgenerate

  assign nib = sh_dig[{idx, 2'b00} +: 4];

  seg7_decoder u_dec (
    .nib (nib),
    .seg (nib_seg)
  );

  // Walk from the top digit down; a digit is dark while all above are zero.
  always_comb begin
    sup        = '0;
    zero_above = 1'b1;
    for (int k = ND - 1; k >= 1; k--) begin
      zero_above = zero_above && (sh_dig[4*k +: 4] == 4'h0);
      sup[k]     = sh_lz && zero_above;
    end
  end

  assign vis = !dead && sh_en[idx] && !sup[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      idx     <= '0;
      sh_dig  <= '0;
      sh_en   <= '0;
      sh_lz   <= 1'b0;
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        idx <= last_idx ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        sh_dig <= bus.digits;
        sh_en  <= bus.digit_en;
        sh_lz  <= bus.lz_blank;
      end
      tick_q  <= frame_end;
      anode_q <= vis ? ~(ND'(1) << idx) : '1;
      seg_q   <= vis ? nib_seg : SEG_BLANK;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench: two scanners (dead time 2 and 0) against a timeline model.
module tb_seg7_scan_mux;

  localparam int ND   = 4;
  localparam int SLOT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int n_tot = 0;
  int n_bad = 0;

  seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus_a ();
  seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus_z ();

  seg7_scan_mux #(
    .NUM_DIGITS (ND),
    .SLOT_CYCLES(SLOT),
    .DEAD_CYCLES(2)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a.slave)
  );

  seg7_scan_mux #(
    .NUM_DIGITS (ND),
    .SLOT_CYCLES(SLOT),
    .DEAD_CYCLES(0)
  ) dut_z (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_z.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  logic [15:0] din;
  logic [3:0]  en_in;
  logic        lz_in;

  always_comb begin
    bus_a.digits   = din;
    bus_a.digit_en = en_in;
    bus_a.lz_blank = lz_in;
    bus_z.digits   = din;
    bus_z.digit_en = en_in;
    bus_z.lz_blank = lz_in;
  end

  // Expected {anode, seg, tick} after the edge that ends cycle t.
  function automatic logic [11:0] exp_out(int t, int dead, logic [15:0] d,
                                          logic [3:0] en, logic lz);
    int pos, k;
    logic tick, sup;
    logic [15:0] hi;
    logic [3:0] an;
    pos  = t % SLOT;
    k    = (t / SLOT) % ND;
    tick = (pos == SLOT - 1) && (k == ND - 1);
    hi   = d >> (4 * k);
    sup  = lz && (k != 0) && (hi == 16'h0);
    if (pos < dead || !en[k] || sup) return {4'hF, 7'h7F, tick};
    an = ~(4'b0001 << k);
    return {an, tbl[hi[3:0]], tick};
  endfunction

  int          t;
  logic [15:0] m_dig;
  logic [3:0]  m_en;
  logic        m_lz;
  logic [11:0] q_a[$];
  logic [11:0] q_z[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t = 0;
      m_dig = '0;
      m_en = '0;
      m_lz = 1'b0;
      q_a.delete();
      q_z.delete();
    end else begin
      q_a.push_back(exp_out(t, 2, m_dig, m_en, m_lz));
      q_z.push_back(exp_out(t, 0, m_dig, m_en, m_lz));
      if ((t % (SLOT * ND)) == SLOT * ND - 1) begin
        m_dig = din;
        m_en  = en_in;
        m_lz  = lz_in;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (reset && q_a.size() > 0 && q_z.size() > 0) begin
      check("dead2", {bus_a.anode, bus_a.seg, bus_a.frame_tick},
            q_a.pop_front());
      check("dead0", {bus_z.anode, bus_z.seg, bus_z.frame_tick},
            q_z.pop_front());
      check("onehot", 32'($countones(~bus_z.anode) <= 1), 32'd1);
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    din   = 16'h0;
    en_in = 4'h0;
    lz_in = 1'b0;
    reset = 1'b0;
    run(3);
    #1;
    check("rst_anode", 32'(bus_a.anode), 32'hF);
    check("rst_seg", 32'(bus_a.seg), 32'h7F);
    check("rst_tick", 32'(bus_a.frame_tick), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    din   = 16'h1234;
    en_in = 4'hF;
    run(32 + 12);
    din = 16'hFFFF;
    run(20 + 32);
    din   = 16'h0070;
    lz_in = 1'b1;
    run(64);
    din = 16'h0000;
    run(64);
    din   = 16'h8888;
    en_in = 4'b0101;
    lz_in = 1'b0;
    run(64);
    begin : wait_d2
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(posedge clk);
        #2;
        if (bus_a.anode == 4'b1011) seen = 1;
      end
      check("wait_digit2", 32'(seen), 32'd1);
    end
    reset = 1'b0;
    #1;
    check("async_anode", 32'(bus_a.anode), 32'hF);
    check("async_seg", 32'(bus_a.seg), 32'h7F);
    check("async_anode0", 32'(bus_z.anode), 32'hF);
    run(2);
    reset = 1'b1;
    din   = 16'h1234;
    en_in = 4'hF;
    run(96);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Parametrised successor to the dual-digit multiplexed 7-segment driver.
- Scans NUM_DIGITS common-anode digits from one clock, one digit per slot.
- Adds a programmable refresh divider, a dead-time blanking interval between digits (anti-ghosting), per-digit enables and leading-zero suppression.
- Inputs are latched once per frame so a digit never changes mid-frame (no tearing).
- Sits between the board switch/adder logic and the display transistors and segment pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 2..8.
- SLOT_CYCLES, 1000, clocks per digit slot; must be ≥2.
- DEAD_CYCLES, 50, blanked clocks at the start of each slot; legal range 0..SLOT_CYCLES-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  hex nibbles; digit k = digits[4k+3:4k]; digit 0 is rightmost/least significant.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 keeps that digit dark.
- lz_blank  in  1  leading-zero suppression enable.
- anode  out  NUM_DIGITS  active-low digit select; bit k drives digit k.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- frame_tick  out  1  one-clock pulse when new inputs have been latched.

Behaviour:
- Reset (reset=0, async): slot counter cnt=0, digit index idx=0, shadow registers (digits, digit_en, lz_blank)=0, anode='1 (all off), seg=7'b1111111, frame_tick=0.
- cnt counts 0..SLOT_CYCLES-1 and wraps. On wrap, idx increments 0..NUM_DIGITS-1 and wraps to 0.
- Frame boundary: cnt==SLOT_CYCLES-1 and idx==NUM_DIGITS-1. On that edge:
  - shadow <= {digits, digit_en, lz_blank};
  - frame_tick <= 1 for exactly one clock.
- Inputs are sampled only at frame boundaries. Changes at any other time have no effect until the next boundary.
- Output latency: anode, seg and frame_tick are registered. Each reflects the (cnt, idx, shadow) state of the previous clock, so it lags the internal state by exactly 1 cycle.
- Output rules for the previous-cycle state:
  - Dead time (cnt < DEAD_CYCLES): anode='1, seg=7'h7F.
  - Otherwise, digit idx is visible if shadow_en[idx]=1 and it is not suppressed.
    - Visible: anode has only bit idx low; seg = decode(shadow nibble idx).
    - Not visible: anode='1, seg=7'h7F.
- Leading-zero suppression: applies only when shadow_lz=1. Digit k is suppressed if k≠0 and every shadow nibble j with j≥k is 4'h0. Digit 0 is never suppressed.
- Disabled or suppressed digits still consume their full slot, so the duty cycle of the remaining digits is unchanged.
- At most one anode bit is low in any cycle. During dead time, or when anode='1, seg is always 7'h7F.
- Decode table, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
- First frame after reset: the shadow registers hold 0, so all digits are dark.
- Reset asserted mid-slot: outputs go dark immediately (async). After release, scanning restarts at idx=0, cnt=0.
- Counter widths are $clog2 of the respective ranges. No overflow is possible at the legal parameter limits.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F;
  - seg_t (logic [6:0]);
  - hex_to_seg function holding the 16-entry table above.
- One combinational sub-module, seg7_decoder (nibble in, seg_t out), wrapping hex_to_seg.
- Counters, shadow registers, suppression logic and output registers stay in seg7_scan_mux.

Test Plan (NUM_DIGITS=4, SLOT_CYCLES=8, DEAD_CYCLES=2 unless noted):
- Reset: hold reset=0 for 3 clocks, then release → anode=4'b1111, seg=7'h7F, frame_tick=0; the whole first frame (32 clks) stays dark.
- Basic scan: digits=16'h1234, digit_en=4'hF, lz_blank=0 before the first boundary. In frame 2, each slot shows 2 clocks dark, then 6 clocks of:
  - anode=1110 seg=0011001;
  - anode=1101 seg=0110000;
  - anode=1011 seg=0100100;
  - anode=0111 seg=1111001.
  frame_tick is high for 1 clock, one cycle after each boundary.
- No tearing: change digits to 16'hFFFF mid-frame → the current frame still shows 1234; the next frame shows F (0001110) on all four digits.
- Leading-zero suppression: digits=16'h0070, lz_blank=1, digit_en=4'hF → digits 3 and 2 dark, digit 1 shows 1111000, digit 0 shows 1000000. digits=16'h0000 → only digit 0 lit, showing 1000000.
- Enables: digits=16'h8888, digit_en=4'b0101 → only anode=1110 and 1011 ever go low. Slot timing is unchanged (each lit digit 6 of every 32 clocks).
- Async reset mid-slot, then DEAD_CYCLES=0 variant:
  - reset mid-slot with digit 2 lit → anode=4'b1111 within the same cycle, before the next clock edge; scanning restarts at idx 0.
  - with DEAD_CYCLES=0, the lit digit's anode is low for all 8 clocks of its slot and no cycle has two anode bits low.
